// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
// Destination select encoding used by the top and the bench.
package demux_pkg;

   typedef logic sel_t;

   localparam sel_t SEL_Y0 = 1'b0;
   localparam sel_t SEL_Y1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slot with valid/ready handshake.
// Ports: clk, rst (sync, active-high), wr_en_i/wr_data_i (fill),
//   ready_i (consumer accepts), valid_o/data_o (held word),
//   count_o (transfers delivered; zero unless DEMUX_COUNT_EN).
module demux_out_slot #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  count_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              xfer;

   assign xfer = valid_q & ready_i;

   // A refill in the same cycle as a drain keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (xfer)
         valid_d = 1'b0;
      if (wr_en_i) begin
         valid_d = 1'b1;
         data_d  = wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (xfer)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;
`else
   assign count_o = '0;
`endif

endmodule

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer; in_sel steers each word to y0 or y1.
// Ports: clk, rst, in_* (producer), y0_*/y1_* (consumers), y0/y1_count (DEMUX_COUNT_EN).
module demux1to2_stream
   import demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  sel_t              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] y0_data,
   output logic              y0_valid,
   input  logic              y0_ready,
   output logic [DATA_W-1:0] y1_data,
   output logic              y1_valid,
   input  logic              y1_ready,
   output logic [CNT_W-1:0]  y0_count,
   output logic [CNT_W-1:0]  y1_count
);

   logic accept;
   logic wr0, wr1;

   // Only the selected slot gates the input, so a stalled output
   // never blocks traffic headed to the other one.
   assign in_ready = (in_sel == SEL_Y1) ? (~y1_valid | y1_ready)
                                        : (~y0_valid | y0_ready);

   assign accept = in_valid & in_ready;
   assign wr0    = accept & (in_sel == SEL_Y0);
   assign wr1    = accept & (in_sel == SEL_Y1);

   demux_out_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr0),
      .wr_data_i (in_data),
      .ready_i   (y0_ready),
      .valid_o   (y0_valid),
      .data_o    (y0_data),
      .count_o   (y0_count)
   );

   demux_out_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr1),
      .wr_data_i (in_data),
      .ready_i   (y1_ready),
      .valid_o   (y1_valid),
      .data_o    (y1_data),
      .count_o   (y1_count)
   );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream.
// Table vectors, corner sequences and random traffic against a queue model.
module tb_demux1to2_stream;
   import demux_pkg::*;

   localparam int DW = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   sel_t          in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] y0_data, y1_data;
   logic          y0_valid, y1_valid;
   logic          y0_ready, y1_ready;
   logic [CW-1:0] y0_count, y1_count;

   demux1to2_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0_data  (y0_data),
      .y0_valid (y0_valid),
      .y0_ready (y0_ready),
      .y1_data  (y1_data),
      .y1_valid (y1_valid),
      .y1_ready (y1_ready),
      .y0_count (y0_count),
      .y1_count (y1_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: each output is a FIFO of words not yet delivered,
   // plus a count of delivered words.
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   int            cnt0 = 0;
   int            cnt1 = 0;

   logic          obs_ir, obs_v0, obs_v1;
   logic [DW-1:0] obs_d0, obs_d1;
   logic [CW-1:0] obs_c1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef DEMUX_COUNT_EN
      return CW'(n % (1 << CW));
`else
      return '0;
`endif
   endfunction

   task automatic cycle(input logic [DW-1:0] d, input logic s,
                        input logic v, input logic r0,
                        input logic r1);
      logic e0, e1, eir, p0, p1, acc;
      @(negedge clk);
      in_data  = d;
      in_sel   = s;
      in_valid = v;
      y0_ready = r0;
      y1_ready = r1;
      #1;
      obs_ir = in_ready;
      obs_v0 = y0_valid;
      obs_v1 = y1_valid;
      obs_d0 = y0_data;
      obs_d1 = y1_data;
      obs_c1 = y1_count;
      e0  = q0.size() != 0;
      e1  = q1.size() != 0;
      // A slot can take a word if it is empty or being drained.
      eir = s ? (!e1 || r1) : (!e0 || r0);
      chk("in_ready", {31'b0, in_ready}, {31'b0, eir});
      chk("y0_valid", {31'b0, y0_valid}, {31'b0, e0});
      chk("y1_valid", {31'b0, y1_valid}, {31'b0, e1});
      if (e0) chk("y0_data", {24'b0, y0_data}, {24'b0, q0[0]});
      if (e1) chk("y1_data", {24'b0, y1_data}, {24'b0, q1[0]});
      chk("y0_count", {30'b0, y0_count}, {30'b0, exp_cnt(cnt0)});
      chk("y1_count", {30'b0, y1_count}, {30'b0, exp_cnt(cnt1)});
      p0  = e0 && r0;
      p1  = e1 && r1;
      acc = v && eir;
      @(posedge clk);
      if (p0) begin q0.delete(0); cnt0++; end
      if (p1) begin q1.delete(0); cnt1++; end
      if (acc) begin
         if (s) q1.push_back(d);
         else   q0.push_back(d);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      in_sel   = sel_t'($urandom_range(1));
      y0_ready = 1'($urandom_range(1));
      y1_ready = 1'($urandom_range(1));
      repeat (n) @(posedge clk);
      q0.delete();
      q1.delete();
      cnt0 = 0;
      cnt1 = 0;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_y0_valid", {31'b0, y0_valid}, 32'd0);
      chk("rst_y1_valid", {31'b0, y1_valid}, 32'd0);
      chk("rst_y0_data", {24'b0, y0_data}, 32'd0);
      chk("rst_y1_data", {24'b0, y1_data}, 32'd0);
      chk("rst_y0_count", {30'b0, y0_count}, 32'd0);
      chk("rst_y1_count", {30'b0, y1_count}, 32'd0);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic          s, v, r0, r1;
      logic          eir, ev0;
      logic [DW-1:0] ed0;
      logic          ev1;
      logic [DW-1:0] ed1;
   } vec_t;

   vec_t tv[12];

   initial begin
      rst      = 1'b0;
      in_data  = '0;
      in_sel   = SEL_Y0;
      in_valid = 1'b0;
      y0_ready = 1'b0;
      y1_ready = 1'b0;

      // d, s, v, r0, r1 | in_ready, y0v, y0d, y1v, y1d
      tv[0]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tv[1]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
      tv[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
      tv[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tv[4]  = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tv[5]  = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
      tv[6]  = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
      tv[7]  = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
      tv[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h77};
      tv[9]  = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h77};
      tv[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00};
      tv[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

      do_reset(2);

      for (int i = 0; i < 12; i++) begin
         cycle(tv[i].d, tv[i].s, tv[i].v, tv[i].r0, tv[i].r1);
         chk($sformatf("tv%0d_in_ready", i), {31'b0, obs_ir}, {31'b0, tv[i].eir});
         chk($sformatf("tv%0d_y0_valid", i), {31'b0, obs_v0}, {31'b0, tv[i].ev0});
         chk($sformatf("tv%0d_y1_valid", i), {31'b0, obs_v1}, {31'b0, tv[i].ev1});
         if (tv[i].ev0)
            chk($sformatf("tv%0d_y0_data", i), {24'b0, obs_d0}, {24'b0, tv[i].ed0});
         if (tv[i].ev1)
            chk($sformatf("tv%0d_y1_data", i), {24'b0, obs_d1}, {24'b0, tv[i].ed1});
      end

      // Back-to-back alternating traffic, both consumers always ready.
      for (int i = 0; i < 16; i++) begin
         cycle(DW'(8'h40 + i), 1'(i % 2), 1'b1, 1'b1, 1'b1);
         chk("thru_in_ready", {31'b0, obs_ir}, 32'd1);
      end
      cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("thru_drained_y0", {31'b0, obs_v0}, 32'd0);
      chk("thru_drained_y1", {31'b0, obs_v1}, 32'd0);

      // Reset with both slots full discards the words.
      cycle(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(8'hBB, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_y0", {31'b0, obs_v0}, 32'd1);
      chk("full_y1", {31'b0, obs_v1}, 32'd1);
      do_reset(1);

      // Five y1 transfers from reset; the narrow counter wraps.
      for (int i = 0; i < 5; i++)
         cycle(DW'(8'hC0 + i), 1'b1, 1'b1, 1'b1, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DEMUX_COUNT_EN
      chk("y1_count_wrap", {30'b0, obs_c1}, 32'd1);
`else
      chk("y1_count_off", {30'b0, obs_c1}, 32'd0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         cycle(DW'($urandom), 1'($urandom_range(1)),
               1'($urandom_range(3) != 0),
               1'($urandom_range(2) != 0),
               1'($urandom_range(2) != 0));
      for (int i = 0; i < 3; i++)
         cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
